// File: rtl/note_scheduler_if.sv
// Request/slot bundle between melody sources, the beat-grid scheduler and the tone datapath.
interface note_scheduler_if #(
  parameter int VOICES      = 2,
  parameter int NOTE_W      = 4,
  parameter int SAMPLE_BITS = 7
);
  localparam int VW = $clog2(VOICES) + 1;

  logic [VOICES-1:0]        req_valid;
  logic [VOICES*NOTE_W-1:0] req_note;
  logic [VOICES-1:0]        req_long;
  logic [VOICES-1:0]        req_ready;
  logic [VOICES-1:0]        busy;
  logic [SAMPLE_BITS-1:0]   sample_pos;
  logic                     sample_strb;
  logic                     tick_strb;
  logic                     slot_valid;
  logic [VW-1:0]            slot_voice;
  logic [NOTE_W-1:0]        slot_note;
  logic                     slot_gate;

  modport master (
    output req_valid, req_note, req_long,
    input  req_ready, busy, sample_pos, sample_strb, tick_strb,
           slot_valid, slot_voice, slot_note, slot_gate
  );

  modport slave (
    input  req_valid, req_note, req_long,
    output req_ready, busy, sample_pos, sample_strb, tick_strb,
           slot_valid, slot_voice, slot_note, slot_gate
  );
endinterface

// File: rtl/note_scheduler.sv
// Beat-grid note scheduler: times note/space per voice on a tick grid and issues one
// accumulator slot per voice per PWM sample period to a shared tone datapath.
module note_scheduler #(
  parameter int VOICES       = 2,
  parameter int SAMPLE_BITS  = 7,
  parameter int TICK_SAMPLES = 5468,
  parameter int NOTE_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  note_scheduler_if.slave bus
);
  localparam int TW = (TICK_SAMPLES > 1) ? $clog2(TICK_SAMPLES) : 1;
  localparam int VW = $clog2(VOICES) + 1;
  localparam logic [SAMPLE_BITS-1:0] POS_LAST  = '1;
  localparam logic [TW-1:0]          TICK_LAST = TW'(TICK_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, NOTE, SPACE} voice_state_t;

  voice_state_t           state     [VOICES];
  logic [2:0]             remaining [VOICES];
  logic [NOTE_W-1:0]      note      [VOICES];
  logic                   is_long   [VOICES];

  logic [SAMPLE_BITS-1:0] sample_pos;
  logic [TW-1:0]          tick_cnt;
  logic                   sample_strb;
  logic                   tick_strb;
  logic [VOICES-1:0]      ready;
  logic [VOICES-1:0]      busy;

  logic                   slot_valid;
  logic [VW-1:0]          slot_voice;
  logic [NOTE_W-1:0]      slot_note;
  logic                   slot_gate;

  assign sample_strb = (sample_pos == POS_LAST);
  assign tick_strb   = sample_strb & run & (tick_cnt == TICK_LAST);

  always_comb begin
    ready = '0;
    busy  = '0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      ready[v] = ~rst & run & (state[v] == IDLE);
      busy[v]  = (state[v] != IDLE);
    end
  end

  // sample_pos free-runs so the PWM comparator keeps its period even while frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_pos <= '0;
      tick_cnt   <= '0;
    end else begin
      sample_pos <= sample_pos + 1'b1;
      if (sample_strb & run)
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        state[v]     <= IDLE;
        remaining[v] <= '0;
        note[v]      <= '0;
        is_long[v]   <= 1'b0;
      end
    end else if (run) begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        case (state[v])
          IDLE: if (bus.req_valid[v]) begin
            note[v]    <= bus.req_note[v*NOTE_W +: NOTE_W];
            is_long[v] <= bus.req_long[v];
            state[v]   <= ARMED;
          end
          ARMED: if (tick_strb) begin
            state[v]     <= NOTE;
            remaining[v] <= is_long[v] ? 3'd7 : 3'd3;
          end
          NOTE: if (tick_strb) begin
            if (remaining[v] == 3'd1) state[v] <= SPACE;
            else                      remaining[v] <= remaining[v] - 3'd1;
          end
          SPACE: if (tick_strb) state[v] <= IDLE;
          default: state[v] <= IDLE;
        endcase
      end
    end
  end

  // Slot uses pre-edge voice state; a request accepted this cycle cannot gate this slot
  always_ff @(posedge clk) begin
    slot_valid <= 1'b0;
    slot_voice <= '0;
    slot_note  <= '0;
    slot_gate  <= 1'b0;
    if (!rst) begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        if ({1'b0, sample_pos} == (SAMPLE_BITS + 1)'(v)) begin
          slot_valid <= 1'b1;
          slot_voice <= VW'(v);
          slot_note  <= note[v];
          slot_gate  <= (state[v] == NOTE) & run;
        end
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.busy        = busy;
  assign bus.sample_pos  = sample_pos;
  assign bus.sample_strb = sample_strb;
  assign bus.tick_strb   = tick_strb;
  assign bus.slot_valid  = slot_valid;
  assign bus.slot_voice  = slot_voice;
  assign bus.slot_note   = slot_note;
  assign bus.slot_gate   = slot_gate;
endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler on a small grid: 8-clock sample period, 32-clock tick.
module tb_note_scheduler;
  localparam int VOICES = 2, SAMPLE_BITS = 3, TICK_SAMPLES = 4, NOTE_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  int   errors = 0;
  int   checks = 0;

  note_scheduler_if #(.VOICES(VOICES), .NOTE_W(NOTE_W), .SAMPLE_BITS(SAMPLE_BITS)) bus ();

  note_scheduler #(
    .VOICES(VOICES), .SAMPLE_BITS(SAMPLE_BITS), .TICK_SAMPLES(TICK_SAMPLES), .NOTE_W(NOTE_W)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_wait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tick_strb === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '0; bus.req_note = '0; bus.req_long = '0;
    rst = 1'b1; run = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.sample_pos !== 3'd0) begin errors++; $display("FAIL rst_pos: got %0d want 0", bus.sample_pos); end
    checks++; if (bus.busy !== 2'b00) begin errors++; $display("FAIL rst_busy: got %b want 00", bus.busy); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", bus.req_ready); end
    checks++; if (bus.slot_valid !== 1'b0) begin errors++; $display("FAIL rst_slot_valid: got %b want 0", bus.slot_valid); end
    checks++; if (bus.slot_gate !== 1'b0) begin errors++; $display("FAIL rst_gate: got %b want 0", bus.slot_gate); end
    checks++; if (bus.tick_strb !== 1'b0 || bus.sample_strb !== 1'b0) begin errors++; $display("FAIL rst_strb: got %b%b want 00", bus.tick_strb, bus.sample_strb); end
    checks++; if (bus.slot_voice !== 2'd0 || bus.slot_note !== 4'd0) begin errors++; $display("FAIL rst_slot: got v%0d n%0d want 0 0", bus.slot_voice, bus.slot_note); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b11) begin errors++; $display("FAIL rst_release_ready: got %b want 11", bus.req_ready); end
  endtask

  task automatic test_idle_grid();
    int prev;
    logic exp_valid;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      prev = (k - 1) % 8;
      exp_valid = (prev < 2);
      checks++; if (bus.sample_pos !== 3'(k % 8)) begin errors++; $display("FAIL grid_pos k=%0d: got %0d want %0d", k, bus.sample_pos, k % 8); end
      checks++; if (bus.slot_valid !== exp_valid) begin errors++; $display("FAIL grid_valid k=%0d: got %b want %b", k, bus.slot_valid, exp_valid); end
      checks++; if (bus.slot_voice !== (exp_valid ? 2'(prev) : 2'd0)) begin errors++; $display("FAIL grid_voice k=%0d: got %0d", k, bus.slot_voice); end
      checks++; if (bus.slot_gate !== 1'b0) begin errors++; $display("FAIL grid_gate k=%0d: got %b want 0", k, bus.slot_gate); end
      checks++; if (bus.tick_strb !== (k % 32 == 31)) begin errors++; $display("FAIL grid_tick k=%0d: got %b want %b", k, bus.tick_strb, (k % 32 == 31)); end
      checks++; if (bus.sample_strb !== (k % 8 == 7)) begin errors++; $display("FAIL grid_sstrb k=%0d: got %b", k, bus.sample_strb); end
    end
  endtask

  task automatic test_short_note();
    bit ok, done;
    int busy_cnt, gated, after;
    busy_cnt = 0; gated = 0; after = 0; done = 1'b0;
    tick_wait(ok);
    checks++; if (!ok) begin errors++; $display("FAIL short_tick_wait: got timeout want tick_strb"); end
    @(negedge clk);
    checks++; if (bus.req_ready[0] !== 1'b1) begin errors++; $display("FAIL short_ready_pre: got %b want 1", bus.req_ready[0]); end
    bus.req_valid = 2'b01; bus.req_note[3:0] = 4'd5; bus.req_long[0] = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      bus.req_valid = '0;
      if (i == 0) begin
        checks++; if (bus.busy[0] !== 1'b1 || bus.req_ready[0] !== 1'b0) begin errors++; $display("FAIL short_accept: got busy=%b ready=%b want 1 0", bus.busy[0], bus.req_ready[0]); end
      end
      if (bus.busy[0] === 1'b1) begin
        busy_cnt++;
        if (bus.slot_valid === 1'b1 && bus.slot_voice === 2'd0) begin
          if (bus.slot_gate === 1'b1) begin
            gated++;
            checks++; if (bus.slot_note !== 4'd5) begin errors++; $display("FAIL short_note: got %0d want 5", bus.slot_note); end
          end else if (gated > 0) after++;
        end
      end else begin
        done = 1'b1;
        checks++; if (bus.req_ready[0] !== 1'b1) begin errors++; $display("FAIL short_ready_post: got %b want 1", bus.req_ready[0]); end
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL short_done: got still busy want idle"); end
    checks++; if (busy_cnt !== 159) begin errors++; $display("FAIL short_busy_cycles: got %0d want 159", busy_cnt); end
    checks++; if (gated !== 12) begin errors++; $display("FAIL short_gated: got %0d want 12", gated); end
    checks++; if (after !== 4) begin errors++; $display("FAIL short_space_slots: got %0d want 4", after); end
  endtask

  task automatic test_long_on_tick();
    bit ok, done;
    int busy_cnt, gated, first;
    busy_cnt = 0; gated = 0; first = 0; done = 1'b0;
    tick_wait(ok);
    checks++; if (!ok) begin errors++; $display("FAIL long_tick_wait: got timeout want tick_strb"); end
    checks++; if (bus.req_ready[1] !== 1'b1) begin errors++; $display("FAIL long_ready_pre: got %b want 1", bus.req_ready[1]); end
    bus.req_valid = 2'b10; bus.req_note[7:4] = 4'd9; bus.req_long[1] = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      bus.req_valid = '0;
      if (i == 0) begin
        checks++; if (bus.busy[1] !== 1'b1) begin errors++; $display("FAIL long_accept: got busy=%b want 1", bus.busy[1]); end
      end
      if (bus.busy[1] === 1'b1) begin
        busy_cnt++;
        if (bus.slot_valid === 1'b1 && bus.slot_voice === 2'd1 && bus.slot_gate === 1'b1) begin
          gated++;
          if (first == 0) first = i + 1;
          checks++; if (bus.slot_note !== 4'd9) begin errors++; $display("FAIL long_note: got %0d want 9", bus.slot_note); end
        end
      end else done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL long_done: got still busy want idle"); end
    checks++; if (first !== 35) begin errors++; $display("FAIL long_first_gate: got cycle %0d want 35", first); end
    checks++; if (gated !== 28) begin errors++; $display("FAIL long_gated: got %0d want 28", gated); end
    checks++; if (busy_cnt !== 288) begin errors++; $display("FAIL long_busy_cycles: got %0d want 288", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok, done, prev_v0;
    int b0, b1, g0, g1, pairs;
    b0 = 0; b1 = 0; g0 = 0; g1 = 0; pairs = 0; done = 1'b0; prev_v0 = 1'b0;
    tick_wait(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_tick_wait: got timeout want tick_strb"); end
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b11) begin errors++; $display("FAIL b2b_ready_pre: got %b want 11", bus.req_ready); end
    bus.req_valid = 2'b11; bus.req_note = {4'd7, 4'd2}; bus.req_long = 2'b00;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      bus.req_valid = '0;
      if (i == 0) begin
        checks++; if (bus.busy !== 2'b11) begin errors++; $display("FAIL b2b_accept: got %b want 11", bus.busy); end
      end
      if (bus.busy[0] === 1'b1) b0++;
      if (bus.busy[1] === 1'b1) b1++;
      if (bus.busy === 2'b00) done = 1'b1;
      if (bus.slot_valid === 1'b1 && bus.slot_gate === 1'b1 && bus.slot_voice === 2'd0) begin
        g0++;
        checks++; if (bus.slot_note !== 4'd2) begin errors++; $display("FAIL b2b_note0: got %0d want 2", bus.slot_note); end
      end
      if (bus.slot_valid === 1'b1 && bus.slot_gate === 1'b1 && bus.slot_voice === 2'd1) begin
        g1++;
        if (prev_v0) pairs++;
        checks++; if (bus.slot_note !== 4'd7) begin errors++; $display("FAIL b2b_note1: got %0d want 7", bus.slot_note); end
      end
      prev_v0 = (bus.slot_valid === 1'b1 && bus.slot_gate === 1'b1 && bus.slot_voice === 2'd0);
    end
    checks++; if (!done) begin errors++; $display("FAIL b2b_done: got still busy want idle"); end
    checks++; if (b0 !== 159 || b1 !== 159) begin errors++; $display("FAIL b2b_busy_cycles: got %0d/%0d want 159/159", b0, b1); end
    checks++; if (g0 !== 12 || g1 !== 12) begin errors++; $display("FAIL b2b_gated: got %0d/%0d want 12/12", g0, g1); end
    checks++; if (pairs !== 12) begin errors++; $display("FAIL b2b_interleave: got %0d want 12", pairs); end
  endtask

  task automatic test_pause();
    bit ok, done;
    int ticks, gated;
    ticks = 0; gated = 0; done = 1'b0;
    tick_wait(ok);
    checks++; if (!ok) begin errors++; $display("FAIL pause_tick_wait0: got timeout want tick_strb"); end
    @(negedge clk);
    bus.req_valid = 2'b01; bus.req_note[3:0] = 4'd3; bus.req_long[0] = 1'b1;
    @(negedge clk);
    bus.req_valid = '0;
    tick_wait(ok);
    checks++; if (!ok) begin errors++; $display("FAIL pause_tick_wait1: got timeout want tick_strb"); end
    tick_wait(ok);
    checks++; if (!ok) begin errors++; $display("FAIL pause_tick_wait2: got timeout want tick_strb"); end
    @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++; if (bus.slot_gate !== 1'b0) begin errors++; $display("FAIL pause_gate i=%0d: got %b want 0", i, bus.slot_gate); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL pause_ready i=%0d: got %b want 00", i, bus.req_ready); end
      checks++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL pause_busy i=%0d: got %b want 1", i, bus.busy[0]); end
      checks++; if (bus.tick_strb !== 1'b0) begin errors++; $display("FAIL pause_tick i=%0d: got %b want 0", i, bus.tick_strb); end
    end
    run = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (bus.busy[0] === 1'b1) begin
        if (bus.tick_strb === 1'b1) ticks++;
        if (bus.slot_valid === 1'b1 && bus.slot_voice === 2'd0 && bus.slot_gate === 1'b1) begin
          gated++;
          checks++; if (bus.slot_note !== 4'd3) begin errors++; $display("FAIL pause_note: got %0d want 3", bus.slot_note); end
        end
      end else done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL pause_done: got still busy want idle"); end
    checks++; if (ticks !== 7) begin errors++; $display("FAIL pause_ticks_left: got %0d want 7", ticks); end
    checks++; if (gated !== 23) begin errors++; $display("FAIL pause_gated: got %0d want 23", gated); end
  endtask

  task automatic test_mid_reset();
    bit ok, found;
    int first;
    found = 1'b0; first = 0;
    tick_wait(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mrst_tick_wait: got timeout want tick_strb"); end
    @(negedge clk);
    bus.req_valid = 2'b10; bus.req_note[7:4] = 4'd11; bus.req_long[1] = 1'b1;
    @(negedge clk);
    bus.req_valid = '0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.slot_valid === 1'b1 && bus.slot_voice === 2'd1 && bus.slot_gate === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mrst_gate_seen: got none want gated v1 slot"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 2'b00) begin errors++; $display("FAIL mrst_busy: got %b want 00", bus.busy); end
    checks++; if (bus.slot_gate !== 1'b0 || bus.slot_valid !== 1'b0) begin errors++; $display("FAIL mrst_slot: got gate=%b valid=%b want 0 0", bus.slot_gate, bus.slot_valid); end
    checks++; if (bus.sample_pos !== 3'd0) begin errors++; $display("FAIL mrst_pos: got %0d want 0", bus.sample_pos); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL mrst_ready: got %b want 00", bus.req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b11) begin errors++; $display("FAIL mrst_ready_release: got %b want 11", bus.req_ready); end
    bus.req_valid = 2'b01; bus.req_note[3:0] = 4'd4; bus.req_long[0] = 1'b0;
    for (int i = 0; i < 100 && first == 0; i++) begin
      @(negedge clk);
      bus.req_valid = '0;
      if (i == 0) begin
        checks++; if (bus.busy !== 2'b01) begin errors++; $display("FAIL mrst_accept: got %b want 01", bus.busy); end
      end
      if (bus.slot_valid === 1'b1 && bus.slot_voice === 2'd0 && bus.slot_gate === 1'b1) begin
        first = i + 1;
        checks++; if (bus.slot_note !== 4'd4) begin errors++; $display("FAIL mrst_note: got %0d want 4", bus.slot_note); end
      end
    end
    checks++; if (first !== 33) begin errors++; $display("FAIL mrst_first_gate: got cycle %0d want 33", first); end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_note = '0; bus.req_long = '0;
    test_reset();
    test_idle_grid();
    test_short_note();
    test_long_on_tick();
    test_back_to_back();
    test_pause();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
